vram_loader: RTL and testbench

//  Upstream fill engine for video RAM on write_clk. Replaces the free-running write address

---
 rtl/vram_loader_if.sv | 23 ++
 rtl/vram_loader.sv | 79 +++++++
 tb/tb_vram_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vram_loader_if.sv
// vram_loader_if: start/busy/done handshake plus ROM read and VRAM write buses of the fill engine
interface vram_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic start;
  logic [ADDR_W-1:0] rom_ad;
  logic [DATA_W-1:0] rom_data;
  logic vram_ce;
  logic [ADDR_W-1:0] vram_ad;
  logic [DATA_W-1:0] vram_data;
  logic busy;
  logic done;
  logic [7:0] frame_cnt;
  modport master (
    input start, rom_data,
    output rom_ad, vram_ce, vram_ad, vram_data, busy, done, frame_cnt
  );
  modport slave (
    output start, rom_data,
    input rom_ad, vram_ce, vram_ad, vram_data, busy, done, frame_cnt
  );
endinterface

// File: rtl/vram_loader.sv
// vram_loader: copies image ROM into video RAM once per fill with start/busy/done handshake.
// LOADER_SWAP_RB_EN: exchange RGB565 R and B fields on the way into VRAM.
module vram_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int ROM_LATENCY = 1,
  parameter int PACE_LOG2 = 0,
  parameter int AUTO_START = 1
) (
  input logic write_clk,
  input logic rst,
  vram_loader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic armed, tick, issue, drained;
  logic [ROM_LATENCY-1:0] vld;
  logic [ADDR_W-1:0] tag [ROM_LATENCY];
  logic [DATA_W-1:0] wdata;
`ifdef LOADER_SWAP_RB_EN
  assign wdata = {bus.rom_data[4:0], bus.rom_data[10:5], bus.rom_data[15:11]};
`else
  assign wdata = bus.rom_data;
`endif
  generate
    if (PACE_LOG2 == 0) begin : g_free
      assign tick = 1'b1;
    end else begin : g_pace
      logic [PACE_LOG2-1:0] pace;
      // reads issue as the counter rolls over, so every slot spans a full pace period
      always_ff @(posedge write_clk or negedge rst)
        if (!rst) pace <= '0;
        else pace <= state == FILL ? pace + 1'b1 : '0;
      assign tick = &pace;
    end
  endgenerate
  assign issue = state == FILL && tick;
  assign drained = !(|vld) && bus.vram_ce && &bus.vram_ad;
  assign bus.busy = state == FILL || state == DRAIN;
  assign bus.done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start || armed ? FILL : IDLE;
      FILL: state_n = issue && &bus.rom_ad ? DRAIN : FILL;
      DRAIN: state_n = drained ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge write_clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge write_clk or negedge rst)
    if (!rst) begin
      armed <= AUTO_START != 0;
      bus.rom_ad <= '0;
      bus.vram_ce <= 1'b0;
      bus.vram_ad <= '0;
      bus.vram_data <= '0;
      bus.frame_cnt <= '0;
      vld <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) tag[i] <= '0;
    end else begin
      armed <= 1'b0;
      bus.rom_ad <= state == IDLE ? '0 : issue ? bus.rom_ad + 1'b1 : bus.rom_ad;
      vld[0] <= issue;
      tag[0] <= bus.rom_ad;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
      bus.vram_ce <= vld[ROM_LATENCY-1];
      if (vld[ROM_LATENCY-1]) begin
        bus.vram_ad <= tag[ROM_LATENCY-1];
        bus.vram_data <= wdata;
      end
      if (state == DRAIN && drained) bus.frame_cnt <= bus.frame_cnt + 8'd1;
    end
endmodule

// File: tb/tb_vram_loader.sv
// tb_vram_loader: three loader configurations checked against a cycle-timing model of each fill
module tb_vram_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst1 = 1'b1;
  int cyc = 0, pass = 0, total = 0;
  logic [15:0] mem [3][16];
  logic [15:0] cap [3][16];
  logic [15:0] p0, p1;
  logic [15:0] p2 [3];
  int e0 [3], wcnt [3], fills [3];
  bit in_fill [3], pend [3], arm [3];
  typedef struct {int ad; logic [15:0] rom; logic [15:0] plain; logic [15:0] swapped;} vec_t;
  vec_t tbl [6];

  vram_loader_if #(.ADDR_W(4), .DATA_W(16)) bus0 ();
  vram_loader_if #(.ADDR_W(4), .DATA_W(16)) bus1 ();
  vram_loader_if #(.ADDR_W(4), .DATA_W(16)) bus2 ();
  vram_loader #(.ADDR_W(4), .DATA_W(16), .ROM_LATENCY(1), .PACE_LOG2(0), .AUTO_START(0))
    u0 (.write_clk(clk), .rst(rst0), .bus(bus0));
  vram_loader #(.ADDR_W(4), .DATA_W(16), .ROM_LATENCY(1), .PACE_LOG2(2), .AUTO_START(1))
    u1 (.write_clk(clk), .rst(rst1), .bus(bus1));
  vram_loader #(.ADDR_W(4), .DATA_W(16), .ROM_LATENCY(3), .PACE_LOG2(0), .AUTO_START(0))
    u2 (.write_clk(clk), .rst(rst0), .bus(bus2));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p0 <= mem[0][bus0.rom_ad];
    p1 <= mem[1][bus1.rom_ad];
    p2[0] <= mem[2][bus2.rom_ad];
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign bus0.rom_data = p0;
  assign bus1.rom_data = p1;
  assign bus2.rom_data = p2[2];

  function automatic logic [15:0] xf(input logic [15:0] w);
`ifdef LOADER_SWAP_RB_EN
    return {w[4:0], w[10:5], w[15:11]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Fill of DEPTH=16 entered at e0: write k lands at e0+(k+1)*2**P+L, done at e0+16*2**P+L+1.
  task automatic mon(input int id, input int pl, input int lat, input logic rs, input logic as,
                     input logic st, input logic ce, input logic bz, input logic dn,
                     input logic [3:0] ad, input logic [15:0] dt, input logic [7:0] fc);
    int per, endc, rel, k;
    bit ew;
    per = 1 << pl;
    endc = 16 * per + lat + 1;
    if (!rs) begin
      in_fill[id] = 0;
      fills[id] = 0;
      pend[id] = 0;
      arm[id] = as;
      chk("reset_outputs", {ce, bz, dn, ad, dt, fc}, 0);
      return;
    end
    if (!in_fill[id]) begin
      chk("fill_start", bz, pend[id]);
      chk("idle_quiet", {ce, dn}, 0);
      if (bz) begin
        in_fill[id] = 1;
        e0[id] = cyc;
        wcnt[id] = 0;
      end else begin
        pend[id] = st | arm[id];
        arm[id] = 0;
      end
    end
    if (in_fill[id]) begin
      rel = cyc - e0[id];
      ew = rel > lat && (rel - lat) % per == 0 && (rel - lat) / per <= 16;
      k = (rel - lat) / per - 1;
      chk("vram_ce", ce, ew);
      if (ew) begin
        chk("vram_ad", ad, k);
        chk("vram_data", dt, xf(mem[id][k]));
        cap[id][k] = dt;
        wcnt[id]++;
      end
      chk("busy", bz, rel < endc);
      chk("done", dn, rel == endc);
      if (rel == endc) begin
        fills[id]++;
        chk("frame_cnt", fc, fills[id] % 256);
        chk("write_count", wcnt[id], 16);
        in_fill[id] = 0;
        pend[id] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 0, 1, rst0, 1'b0, bus0.start, bus0.vram_ce, bus0.busy, bus0.done, bus0.vram_ad, bus0.vram_data, bus0.frame_cnt);
    mon(1, 2, 1, rst1, 1'b1, bus1.start, bus1.vram_ce, bus1.busy, bus1.done, bus1.vram_ad, bus1.vram_data, bus1.frame_cnt);
    mon(2, 0, 3, rst0, 1'b0, bus2.start, bus2.vram_ce, bus2.busy, bus2.done, bus2.vram_ad, bus2.vram_data, bus2.frame_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fills(input int id, input int n, input int budget);
    for (int i = 0; i < budget && fills[id] < n; i++) tick();
    chk("fill_timeout", fills[id] >= n, 1);
  endtask

  initial begin
    tbl[0] = '{5, 16'hF800, 16'hF800, 16'h001F};
    tbl[1] = '{6, 16'h001F, 16'h001F, 16'hF800};
    tbl[2] = '{7, 16'h07E0, 16'h07E0, 16'h07E0};
    tbl[3] = '{8, 16'h1234, 16'h1234, 16'hA222};
    tbl[4] = '{0, 16'hA000, 16'hA000, 16'h0014};
    tbl[5] = '{15, 16'hA00F, 16'hA00F, 16'h7814};
    for (int j = 0; j < 16; j++) for (int m = 0; m < 3; m++) mem[m][j] = 16'hA000 + 16'(j);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b1;
    #2 rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (3) tick();
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 6; i++) mem[0][tbl[i].ad] = tbl[i].rom;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_fills(0, 1, 100);
    for (int i = 0; i < 6; i++)
`ifdef LOADER_SWAP_RB_EN
      chk("table_word", cap[0][tbl[i].ad], tbl[i].swapped);
`else
      chk("table_word", cap[0][tbl[i].ad], tbl[i].plain);
`endif
    chk("first_frame", bus0.frame_cnt, 1);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int i = 0; i < 100 && wcnt[0] < 7; i++) tick();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_fills(0, 2, 100);
    chk("ignored_start_frame", bus0.frame_cnt, 2);
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 16; j++) mem[0][j] = 16'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      bus0.start = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      for (int i = 0; i < 100 && fills[0] < it + 3; i++) begin
        bus0.start = 1'($urandom_range(0, 1));
        tick();
      end
      bus0.start = 1'b0;
      chk("random_fill", fills[0], it + 3);
    end
    wait_fills(1, 1, 200);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int i = 0; i < 200 && !(in_fill[1] && wcnt[1] == 9); i++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_abort_ce", bus1.vram_ce, 1);
    rst1 = 1'b0;
    #1;
    chk("abort_ce", bus1.vram_ce, 0);
    chk("abort_busy", bus1.busy, 0);
    chk("abort_frame_cnt", bus1.frame_cnt, 0);
    repeat (3) tick();
    rst1 = 1'b1;
    wait_fills(1, 1, 200);
    wait_fills(2, 256, 8000);
    bus2.start = 1'b0;
    chk("frame_wrap", bus2.frame_cnt, 0);
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
